// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(parameter int N = 8);
  logic start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic busy;
  logic done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock
module adder_subtractor #(parameter int W = 9) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum
);
  assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, cin};
endmodule

module seq_divider #(parameter int N = 8) (
  input logic clk,
  input logic rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] r, q, d, next_r, next_q;
  logic [N:0] shifted, t;
  logic [CW-1:0] cnt;
  logic z_pend;
  // partial remainder stays below the divisor, so its top bit is never needed in storage
  assign shifted = {r, q[N-1]};
  adder_subtractor #(.W(N + 1)) u_sub (
    .a(shifted), .b({1'b0, d}), .sub(1'b1), .cin(1'b1), .sum(t)
  );
  assign next_r = t[N] ? shifted[N-1:0] : t[N-1:0];
  assign next_q = {q[N-2:0], ~t[N]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      z_pend <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        RUN: begin
          r <= next_r;
          q <= next_q;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.quotient <= next_q;
            bus.remainder <= next_r;
            bus.div_by_zero <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          // zero divisor spends one quiet cycle in DONE before publishing, q holds the dividend
          if (z_pend) begin
            z_pend <= 1'b0;
            bus.quotient <= '1;
            bus.remainder <= q;
            bus.div_by_zero <= 1'b1;
            bus.done <= 1'b1;
          end else if (bus.start) begin
            d <= bus.divisor;
            q <= bus.dividend;
            r <= '0;
            cnt <= CW'(N - 1);
            bus.busy <= bus.divisor != '0;
            z_pend <= bus.divisor == '0;
            state <= (bus.divisor != '0) ? RUN : DONE;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
